// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU data-memory bus bundle between the CPU (master) and the timer (slave).
// Latency: none; the interface only carries wires.
// Backpressure: none; the bus has no stall or ready, and every accepted access completes in one cycle.
// Signals:
//   enabler       - access strobe
//   write_enabler - 1 = write, 0 = read
//   addr          - byte address
//   select        - byte lanes for writes
//   data_input    - write data
//   data_output   - registered read data (driven by the timer)
//   hit           - combinational address decode (driven by the timer)
interface mmio_timer_if;
    logic        enabler;
    logic        write_enabler;
    logic [31:0] addr;
    logic [3:0]  select;
    logic [31:0] data_input;
    logic [31:0] data_output;
    logic        hit;

    modport master (
        output enabler,
        output write_enabler,
        output addr,
        output select,
        output data_input,
        input  data_output,
        input  hit
    );

    modport slave (
        input  enabler,
        input  write_enabler,
        input  addr,
        input  select,
        input  data_input,
        output data_output,
        output hit
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with one-shot/periodic expiry, sticky status and level irq.
// Latency: writes take effect at the clock edge; read data is registered (1 cycle); irq is combinational from registers.
// Backpressure: none; every access with enabler & hit is accepted in the cycle it is presented.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mmio_timer_if.slave (enabler, write_enabler, addr, select, data_input -> data_output, hit)
//   irq  - level interrupt = STATUS.expired & CTRL.irq_en
//
// Register map (addr[3:2]): 0 CTRL {prescale[15:8], irq_en[2], auto_reload[1], run[0]},
//                           1 LOAD, 2 COUNT, 3 STATUS {expired[0], write-1-to-clear}.
// Build option: define MMIO_TIMER_PRESCALER_EN to add the 8-bit prescaler in CTRL[15:8];
//               without it CTRL[15:8] reads 0 and the timer ticks every cycle while running.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned WIDTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    mmio_timer_if.slave bus,
    output logic        irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic             run_q;
    logic             auto_q;
    logic             irq_en_q;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] count_q;
    logic             expired_q;
    logic [31:0]      dout_q;

`ifdef MMIO_TIMER_PRESCALER_EN
    logic [7:0]       pre_q;     // prescale value P from CTRL[15:8]
    logic [7:0]       pcnt_q;    // cycles elapsed in the current prescale period
    logic [7:0]       pre_d;
    logic [7:0]       pcnt_d;
`endif

    logic             run_d;
    logic             auto_d;
    logic             irq_en_d;
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] count_d;
    logic             expired_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        access;
    logic        wr_acc;
    logic        rd_acc;
    logic [1:0]  reg_idx;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        w1c;
    logic [31:0] lane_mask;

    assign bus.hit   = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign access    = bus.enabler & bus.hit;
    assign wr_acc    = access & bus.write_enabler;
    assign rd_acc    = access & ~bus.write_enabler;
    assign reg_idx   = bus.addr[3:2];

    assign wr_ctrl   = wr_acc && (reg_idx == REG_CTRL);
    assign wr_load   = wr_acc && (reg_idx == REG_LOAD);
    assign wr_count  = wr_acc && (reg_idx == REG_COUNT);
    assign wr_status = wr_acc && (reg_idx == REG_STATUS);
    assign w1c       = wr_status & bus.select[0] & bus.data_input[0];

    assign lane_mask = {{8{bus.select[3]}}, {8{bus.select[2]}},
                        {8{bus.select[1]}}, {8{bus.select[0]}}};

    // Byte addr[1:0] is deliberately ignored: every access is a word access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[1:0];

    // Merge write data into an existing 32-bit view, one byte lane at a time.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        lane_merge = (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [31:0] load_ext;
    logic [31:0] count_ext;
    logic [31:0] load_merged;
    logic [31:0] count_merged;

    assign load_ext     = 32'(load_q);
    assign count_ext    = 32'(count_q);
    assign load_merged  = lane_merge(load_ext, bus.data_input, lane_mask);
    assign count_merged = lane_merge(count_ext, bus.data_input, lane_mask);

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic tick;
    logic tick_eff;
    logic expire_evt;

`ifdef MMIO_TIMER_PRESCALER_EN
    assign tick = run_q && (pcnt_q == pre_q);

    // The prescale phase restarts whenever the timer is stopped or software
    // rewrites CTRL/COUNT, so a fresh start always waits a full P+1 cycles.
    always_comb begin
        pcnt_d = pcnt_q;
        if (!run_q || wr_ctrl || wr_count) begin
            pcnt_d = 8'd0;
        end else if (pcnt_q == pre_q) begin
            pcnt_d = 8'd0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end
`else
    assign tick = run_q;
`endif

    // A CPU write to COUNT swallows a coincident tick entirely, including
    // any expiry it would have produced.
    assign tick_eff   = tick & ~wr_count;
    assign expire_evt = tick_eff && (count_q == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        run_d     = run_q;
        auto_d    = auto_q;
        irq_en_d  = irq_en_q;
        load_d    = load_q;
        count_d   = count_q;
`ifdef MMIO_TIMER_PRESCALER_EN
        pre_d     = pre_q;
`endif

        // Timer progress first, so CPU writes below override it.
        if (tick_eff) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                run_d = 1'b0;
            end
        end

        if (wr_ctrl && bus.select[0]) begin
            run_d    = bus.data_input[0];
            auto_d   = bus.data_input[1];
            irq_en_d = bus.data_input[2];
        end
`ifdef MMIO_TIMER_PRESCALER_EN
        if (wr_ctrl && bus.select[1]) begin
            pre_d = bus.data_input[15:8];
        end
`endif
        if (wr_load) begin
            load_d = load_merged[WIDTH-1:0];
        end
        if (wr_count) begin
            count_d = count_merged[WIDTH-1:0];
        end

        // Set beats clear so an expiry is never lost to a racing W1C.
        expired_d = (expired_q & ~w1c) | expire_evt;
    end

    // ------------------------------------------------------------------
    // Read mux (pre-update register values)
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            REG_CTRL: begin
                rdata[0] = run_q;
                rdata[1] = auto_q;
                rdata[2] = irq_en_q;
`ifdef MMIO_TIMER_PRESCALER_EN
                rdata[15:8] = pre_q;
`endif
            end
            REG_LOAD:   rdata = load_ext;
            REG_COUNT:  rdata = count_ext;
            REG_STATUS: rdata[0] = expired_q;
            default:    rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q     <= 1'b0;
            auto_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            dout_q    <= 32'd0;
`ifdef MMIO_TIMER_PRESCALER_EN
            pre_q     <= 8'd0;
            pcnt_q    <= 8'd0;
`endif
        end else begin
            run_q     <= run_d;
            auto_q    <= auto_d;
            irq_en_q  <= irq_en_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
`ifdef MMIO_TIMER_PRESCALER_EN
            pre_q     <= pre_d;
            pcnt_q    <= pcnt_d;
`endif
            // Read data only changes on an accepted read; otherwise it holds.
            if (rd_acc) begin
                dout_q <= rdata;
            end
        end
    end

    assign bus.data_output = dout_q;
    assign irq             = expired_q & irq_en_q;

endmodule
